// File: rtl/iter_divide_pkg.sv
// Shared definitions for the iterative divider.
// Contents: FSM state enum, representation string constants, and a
// two's-complement magnitude helper that works on a 64-bit container.
package cnn_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    localparam string REP_UNSIGNED = "UNSIGNED";
    localparam string REP_SIGNED   = "SIGNED";

    // Widest operand the magnitude helper can handle.
    localparam int unsigned MAG_W = 64;

    // Magnitude of a sign-extended two's complement value. The most-negative
    // value maps to 2^(w-1), which is still correct once truncated back to w bits.
    function automatic logic [MAG_W-1:0] twos_mag(input logic [MAG_W-1:0] v);
        return v[MAG_W-1] ? (~v + MAG_W'(1)) : v;
    endfunction

endpackage

// File: rtl/iter_divide_if.sv
// Start/busy/done handshake and operand/result bus for iter_divide.
// Signals: start, numer[WN], denom[WD] (requester -> divider);
//          busy, done, quotient[WN], remain[WD], div_by_zero (divider -> requester).
// master: the requester side; slave: the divider side.
interface iter_divide_if #(
    parameter int unsigned WN = 16,
    parameter int unsigned WD = 8
);
    logic          start;
    logic [WN-1:0] numer;
    logic [WD-1:0] denom;
    logic          busy;
    logic          done;
    logic [WN-1:0] quotient;
    logic [WD-1:0] remain;
    logic          div_by_zero;

    modport master (
        output start, numer, denom,
        input  busy, done, quotient, remain, div_by_zero
    );

    modport slave (
        input  start, numer, denom,
        output busy, done, quotient, remain, div_by_zero
    );
endinterface

// File: rtl/iter_divide_div_step.sv
// One combinational restoring-division step.
// Ports: rem_i     current partial remainder (WD bits, always < den_i)
//        num_bit_i next numerator bit shifted into the partial remainder
//        den_i     divisor magnitude
//        rem_o     next partial remainder
//        q_o       quotient bit produced by this step
module div_step #(
    parameter int unsigned WD = 8
) (
    input  logic [WD-1:0] rem_i,
    input  logic          num_bit_i,
    input  logic [WD-1:0] den_i,
    output logic [WD-1:0] rem_o,
    output logic          q_o
);
    localparam int unsigned PW = WD + 1;

    logic [PW-1:0] partial;
    logic [PW:0]   diff;

    // Extra top bit of diff acts as the borrow/sign of the trial subtraction.
    always_comb begin
        partial = {rem_i, num_bit_i};
        diff    = {1'b0, partial} - {2'b00, den_i};
        q_o     = ~diff[PW];
        rem_o   = q_o ? WD'(diff) : WD'(partial);
    end
endmodule

// File: rtl/iter_divide.sv
// Multi-cycle radix-2 restoring divider (unsigned or two's complement).
// Ports: clock        rising-edge clock
//        aclr         asynchronous active-high clear
//        clken        clock enable; all state holds while low
//        bus (slave)  start/numer/denom in; busy/done/quotient/remain/div_by_zero out
// One divide in flight; done pulses lpm_widthn+1 enabled edges after acceptance.
module iter_divide
    import cnn_div_pkg::*;
#(
    parameter int unsigned lpm_widthn         = 16,
    parameter int unsigned lpm_widthd         = 8,
    parameter string       lpm_representation = REP_UNSIGNED
) (
    input  logic          clock,
    input  logic          aclr,
    input  logic          clken,
    iter_divide_if.slave  bus
);
    localparam int unsigned WN        = lpm_widthn;
    localparam int unsigned WD        = lpm_widthd;
    localparam int unsigned CW        = $clog2(lpm_widthn + 1);
    localparam bit          IS_SIGNED = (lpm_representation == REP_SIGNED);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WN-1:0] num_q, num_d;      // numerator in, quotient magnitude out
    logic [WD-1:0] rem_q, rem_d;
    logic [WD-1:0] den_q, den_d;
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic          dz_q, dz_d;
    logic [WN-1:0] quot_q, quot_d;
    logic [WD-1:0] remo_q, remo_d;
    logic          dzo_q, dzo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [WN-1:0] numer_mag;
    logic [WD-1:0] denom_mag;
    logic          numer_neg;
    logic          denom_neg;
    logic [WD-1:0] step_rem;
    logic          step_bit;

    // Operand magnitudes and signs at the request port.
    always_comb begin
        numer_mag = bus.numer;
        denom_mag = bus.denom;
        numer_neg = 1'b0;
        denom_neg = 1'b0;
        if (IS_SIGNED) begin
            numer_mag = WN'(twos_mag(MAG_W'($signed(bus.numer))));
            denom_mag = WD'(twos_mag(MAG_W'($signed(bus.denom))));
            numer_neg = bus.numer[WN-1];
            denom_neg = bus.denom[WD-1];
        end
    end

    div_step #(
        .WD (WD)
    ) u_step (
        .rem_i     (rem_q),
        .num_bit_i (num_q[WN-1]),
        .den_i     (den_q),
        .rem_o     (step_rem),
        .q_o       (step_bit)
    );

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        rem_d   = rem_q;
        den_d   = den_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dzo_d   = dzo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    cnt_d   = CW'(WN);
                    num_d   = numer_mag;
                    den_d   = denom_mag;
                    rem_d   = '0;
                    qneg_d  = numer_neg ^ denom_neg;
                    rneg_d  = numer_neg;
                    dz_d    = (bus.denom == '0);
                    busy_d  = 1'b1;
                end
            end
            CALC: begin
                // Quotient bits fill the numerator register from the bottom.
                num_d = {num_q[WN-2:0], step_bit};
                rem_d = step_rem;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dzo_d   = dz_q;
                if (dz_q) begin
                    quot_d = '1;
                    remo_d = '0;
                end else begin
                    quot_d = qneg_q ? (~num_q + WN'(1)) : num_q;
                    remo_d = rneg_q ? (~rem_q + WD'(1)) : rem_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; clken freezes everything including a pending done.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            rem_q   <= '0;
            den_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dzo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (clken) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            den_q   <= den_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dzo_q   <= dzo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remain      = remo_q;
    assign bus.div_by_zero = dzo_q;

endmodule

// File: tb/tb_iter_divide.sv
// Directed bench for iter_divide: an unsigned and a signed instance (n=8, d=4).
module tb_iter_divide;

    logic clk;
    logic aclr;
    logic clken;
    int   n_pass;
    int   n_total;

    iter_divide_if #(.WN(8), .WD(4)) ubus ();
    iter_divide_if #(.WN(8), .WD(4)) sbus ();

    iter_divide #(
        .lpm_widthn         (8),
        .lpm_widthd         (4),
        .lpm_representation ("UNSIGNED")
    ) u_dut (
        .clock (clk),
        .aclr  (aclr),
        .clken (clken),
        .bus   (ubus)
    );

    iter_divide #(
        .lpm_widthn         (8),
        .lpm_widthd         (4),
        .lpm_representation ("SIGNED")
    ) s_dut (
        .clock (clk),
        .aclr  (aclr),
        .clken (clken),
        .bus   (sbus)
    );

    always #5 clk = ~clk;

    // Drive one request; returns #1 after the accepting edge.
    task automatic u_launch(input logic [7:0] n, input logic [3:0] d);
        ubus.numer = n;
        ubus.denom = d;
        ubus.start = 1'b1;
        @(posedge clk); #1;
        ubus.start = 1'b0;
    endtask

    task automatic s_launch(input logic [7:0] n, input logic [3:0] d);
        sbus.numer = n;
        sbus.denom = d;
        sbus.start = 1'b1;
        @(posedge clk); #1;
        sbus.start = 1'b0;
    endtask

    // Counts edges until done is seen, bounded by limit.
    task automatic u_wait_done(input int limit, output int e);
        e = 0;
        while (ubus.done !== 1'b1 && e < limit) begin
            @(posedge clk); #1;
            e++;
        end
    endtask

    task automatic s_wait_done(input int limit, output int e);
        e = 0;
        while (sbus.done !== 1'b1 && e < limit) begin
            @(posedge clk); #1;
            e++;
        end
    endtask

    task automatic test_reset();
        #3;
        n_total++; if (ubus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", ubus.busy); else n_pass++;
        n_total++; if (ubus.done !== 1'b0) $display("FAIL rst_done: got %b want 0", ubus.done); else n_pass++;
        n_total++; if (ubus.quotient !== 8'h00) $display("FAIL rst_quot: got %h want 00", ubus.quotient); else n_pass++;
        n_total++; if (ubus.remain !== 4'h0) $display("FAIL rst_rem: got %h want 0", ubus.remain); else n_pass++;
        n_total++; if (ubus.div_by_zero !== 1'b0) $display("FAIL rst_dz: got %b want 0", ubus.div_by_zero); else n_pass++;
        n_total++; if (sbus.quotient !== 8'h00) $display("FAIL rst_squot: got %h want 00", sbus.quotient); else n_pass++;
        @(posedge clk); #1;
        aclr = 1'b0;
        @(posedge clk); #1;
        n_total++; if (ubus.busy !== 1'b0) $display("FAIL rst_idle_busy: got %b want 0", ubus.busy); else n_pass++;
    endtask

    task automatic test_unsigned();
        int e;
        @(posedge clk); #1;
        u_launch(8'd100, 4'd7);
        n_total++; if (ubus.busy !== 1'b1) $display("FAIL u_busy_accept: got %b want 1", ubus.busy); else n_pass++;
        u_wait_done(40, e);
        n_total++; if (e != 9) $display("FAIL u_latency: got %0d want 9", e); else n_pass++;
        n_total++; if (ubus.quotient !== 8'd14) $display("FAIL u_quot: got %0d want 14", ubus.quotient); else n_pass++;
        n_total++; if (ubus.remain !== 4'd2) $display("FAIL u_rem: got %0d want 2", ubus.remain); else n_pass++;
        n_total++; if (ubus.div_by_zero !== 1'b0) $display("FAIL u_dz: got %b want 0", ubus.div_by_zero); else n_pass++;
        n_total++; if (ubus.busy !== 1'b0) $display("FAIL u_busy_done: got %b want 0", ubus.busy); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (ubus.done !== 1'b0) $display("FAIL u_done_pulse: got %b want 0", ubus.done); else n_pass++;
        n_total++; if (ubus.quotient !== 8'd14) $display("FAIL u_quot_hold: got %0d want 14", ubus.quotient); else n_pass++;
    endtask

    task automatic test_signed();
        int e;
        @(posedge clk); #1;
        s_launch(8'h9C, 4'h7);                     // -100 / 7
        s_wait_done(40, e);
        n_total++; if (e != 9) $display("FAIL s_latency: got %0d want 9", e); else n_pass++;
        n_total++; if (sbus.quotient !== 8'hF2) $display("FAIL s_quot_neg: got %h want f2", sbus.quotient); else n_pass++;
        n_total++; if (sbus.remain !== 4'hE) $display("FAIL s_rem_neg: got %h want e", sbus.remain); else n_pass++;
        n_total++; if (sbus.div_by_zero !== 1'b0) $display("FAIL s_dz: got %b want 0", sbus.div_by_zero); else n_pass++;
        @(posedge clk); #1;
        s_launch(8'h80, 4'hF);                     // -128 / -1
        s_wait_done(40, e);
        n_total++; if (e != 9) $display("FAIL s_mn_latency: got %0d want 9", e); else n_pass++;
        n_total++; if (sbus.quotient !== 8'h80) $display("FAIL s_mn_quot: got %h want 80", sbus.quotient); else n_pass++;
        n_total++; if (sbus.remain !== 4'h0) $display("FAIL s_mn_rem: got %h want 0", sbus.remain); else n_pass++;
        n_total++; if (sbus.div_by_zero !== 1'b0) $display("FAIL s_mn_dz: got %b want 0", sbus.div_by_zero); else n_pass++;
        @(posedge clk); #1;
        s_launch(8'h64, 4'h9);                     // 100 / -7
        s_wait_done(40, e);
        n_total++; if (sbus.quotient !== 8'hF2) $display("FAIL s_pn_quot: got %h want f2", sbus.quotient); else n_pass++;
        n_total++; if (sbus.remain !== 4'h2) $display("FAIL s_pn_rem: got %h want 2", sbus.remain); else n_pass++;
    endtask

    task automatic test_div_zero();
        int e;
        @(posedge clk); #1;
        u_launch(8'd255, 4'd0);
        u_wait_done(40, e);
        n_total++; if (e != 9) $display("FAIL dz_latency: got %0d want 9", e); else n_pass++;
        n_total++; if (ubus.quotient !== 8'hFF) $display("FAIL dz_quot: got %h want ff", ubus.quotient); else n_pass++;
        n_total++; if (ubus.remain !== 4'h0) $display("FAIL dz_rem: got %h want 0", ubus.remain); else n_pass++;
        n_total++; if (ubus.div_by_zero !== 1'b1) $display("FAIL dz_flag: got %b want 1", ubus.div_by_zero); else n_pass++;
        repeat (3) begin @(posedge clk); #1; end
        n_total++; if (ubus.div_by_zero !== 1'b1) $display("FAIL dz_flag_hold: got %b want 1", ubus.div_by_zero); else n_pass++;
        u_launch(8'd200, 4'd13);
        u_wait_done(40, e);
        n_total++; if (ubus.quotient !== 8'd15) $display("FAIL dz_next_quot: got %0d want 15", ubus.quotient); else n_pass++;
        n_total++; if (ubus.remain !== 4'd5) $display("FAIL dz_next_rem: got %0d want 5", ubus.remain); else n_pass++;
        n_total++; if (ubus.div_by_zero !== 1'b0) $display("FAIL dz_next_flag: got %b want 0", ubus.div_by_zero); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int e;
        @(posedge clk); #1;
        u_launch(8'd100, 4'd7);
        ubus.numer = 8'd50;
        ubus.denom = 4'd3;
        // Extra start sampled at edge 3 (CALC) and edge 9 (FIX) after acceptance.
        for (int i = 1; i <= 9; i++) begin
            ubus.start = (i == 3 || i == 9);
            @(posedge clk); #1;
        end
        ubus.start = 1'b0;
        n_total++; if (ubus.done !== 1'b1) $display("FAIL bi_done: got %b want 1", ubus.done); else n_pass++;
        n_total++; if (ubus.quotient !== 8'd14) $display("FAIL bi_quot: got %0d want 14", ubus.quotient); else n_pass++;
        n_total++; if (ubus.remain !== 4'd2) $display("FAIL bi_rem: got %0d want 2", ubus.remain); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (ubus.busy !== 1'b0) $display("FAIL bi_not_accepted: got %b want 0", ubus.busy); else n_pass++;
        u_launch(8'd50, 4'd3);
        n_total++; if (ubus.busy !== 1'b1) $display("FAIL bi_accept_after_done: got %b want 1", ubus.busy); else n_pass++;
        u_wait_done(40, e);
        n_total++; if (e != 9) $display("FAIL bi_latency2: got %0d want 9", e); else n_pass++;
        n_total++; if (ubus.quotient !== 8'd16) $display("FAIL bi_quot2: got %0d want 16", ubus.quotient); else n_pass++;
        n_total++; if (ubus.remain !== 4'd2) $display("FAIL bi_rem2: got %0d want 2", ubus.remain); else n_pass++;
    endtask

    task automatic test_clken();
        int e;
        @(posedge clk); #1;
        u_launch(8'd100, 4'd7);
        repeat (3) begin @(posedge clk); #1; end
        clken = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        n_total++; if (ubus.done !== 1'b0) $display("FAIL ce_no_early_done: got %b want 0", ubus.done); else n_pass++;
        n_total++; if (ubus.busy !== 1'b1) $display("FAIL ce_busy_hold: got %b want 1", ubus.busy); else n_pass++;
        clken = 1'b1;
        u_wait_done(40, e);
        n_total++; if (e + 8 != 14) $display("FAIL ce_latency: got %0d want 14", e + 8); else n_pass++;
        n_total++; if (ubus.quotient !== 8'd14) $display("FAIL ce_quot: got %0d want 14", ubus.quotient); else n_pass++;
        n_total++; if (ubus.remain !== 4'd2) $display("FAIL ce_rem: got %0d want 2", ubus.remain); else n_pass++;
        clken = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_total++; if (ubus.done !== 1'b1) $display("FAIL ce_done_held: got %b want 1", ubus.done); else n_pass++;
        clken = 1'b1;
        @(posedge clk); #1;
        n_total++; if (ubus.done !== 1'b0) $display("FAIL ce_done_release: got %b want 0", ubus.done); else n_pass++;
    endtask

    task automatic test_aclr();
        int e;
        int n_done;
        @(posedge clk); #1;
        u_launch(8'd77, 4'd5);
        repeat (3) begin @(posedge clk); #1; end
        #2;
        aclr = 1'b1;
        #1;
        n_total++; if (ubus.quotient !== 8'h00) $display("FAIL ac_quot: got %h want 00", ubus.quotient); else n_pass++;
        n_total++; if (ubus.remain !== 4'h0) $display("FAIL ac_rem: got %h want 0", ubus.remain); else n_pass++;
        n_total++; if (ubus.busy !== 1'b0) $display("FAIL ac_busy: got %b want 0", ubus.busy); else n_pass++;
        n_total++; if (ubus.div_by_zero !== 1'b0) $display("FAIL ac_dz: got %b want 0", ubus.div_by_zero); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        aclr = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ubus.done === 1'b1) n_done++;
        end
        n_total++; if (n_done != 0) $display("FAIL ac_no_done: got %0d pulses want 0", n_done); else n_pass++;
        u_launch(8'd77, 4'd5);
        u_wait_done(40, e);
        n_total++; if (e != 9) $display("FAIL ac_latency: got %0d want 9", e); else n_pass++;
        n_total++; if (ubus.quotient !== 8'd15) $display("FAIL ac_quot2: got %0d want 15", ubus.quotient); else n_pass++;
        n_total++; if (ubus.remain !== 4'd2) $display("FAIL ac_rem2: got %0d want 2", ubus.remain); else n_pass++;
    endtask

    initial begin
        clk        = 1'b0;
        aclr       = 1'b1;
        clken      = 1'b1;
        n_pass     = 0;
        n_total    = 0;
        ubus.start = 1'b0;
        ubus.numer = '0;
        ubus.denom = '0;
        sbus.start = 1'b0;
        sbus.numer = '0;
        sbus.denom = '0;

        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_busy_ignore();
        test_clken();
        test_aclr();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/iter_divide.md
# iter_divide

Multi-cycle radix-2 restoring divider for the CNN datapath, the inverse counterpart of the `lpm_mult` multiplier primitive. It uses the same `lpm_*` parameter style and the same `clock`/`clken`/`aclr` control set. Layers that need a quotient instantiate it: average-pooling normalisation and scale/shift rescaling after accumulation. One divide is in flight at a time, using a start/busy/done handshake.

## Interface
Parameters:
- `lpm_widthn`, 16: numerator and quotient width (≥2).
- `lpm_widthd`, 8: denominator and remainder width (≥2, ≤ `lpm_widthn`).
- `lpm_representation`, "UNSIGNED": "UNSIGNED" or "SIGNED" (two's complement operands and results).

Ports:
- `clock`  in  1: single clock, rising edge.
- `aclr`  in  1: asynchronous, active-high reset.
- `clken`  in  1: clock enable; when low, all state holds.
- `start`  in  1: request a divide; sampled when idle and `clken`=1.
- `numer`  in  `lpm_widthn`: numerator, captured with `start`.
- `denom`  in  `lpm_widthd`: denominator, captured with `start`.
- `busy`  out  1: high from the cycle after acceptance until `done`.
- `done`  out  1: one-cycle pulse when results update.
- `quotient`  out  `lpm_widthn`: result, held until the next `done`.
- `remain`  out  `lpm_widthd`: remainder, held until the next `done`.
- `div_by_zero`  out  1: flag for the last result, held with it.

## Operation
- State machine: IDLE → CALC → FIX → IDLE.
- IDLE: on `start`=1, the block latches the magnitudes of `numer`/`denom`, the result signs, and a zero-denominator flag. It loads step counter = `lpm_widthn`, then moves to CALC.
- CALC: each enabled cycle runs one restoring step:
  - partial remainder (`lpm_widthd`+1 bits) = {rem, next numerator MSB};
  - subtract the denominator magnitude; if non-negative, keep it and shift in quotient bit 1, else restore and shift in 0;
  - decrement the counter; at 0, go to FIX.
- FIX: applies sign correction and drives the outputs, pulses `done`, then returns to IDLE.
- Signed mode:
  - truncating division, with quotient sign = sign(numer) XOR sign(denom);
  - remainder sign follows the numerator;
  - most-negative / −1 gives quotient = most-negative (wraps) and remainder 0, with no flag.
- Denominator zero: quotient = all ones, remainder = 0, `div_by_zero`=1. There is no sign correction and the latency is unchanged.
- `start` while busy (CALC/FIX) is ignored; there is no queueing.
- `start` in the same cycle as `done` is not accepted. The earliest accept is the cycle after `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remain`=0, `div_by_zero`=0, state IDLE, counter 0.
- `aclr` mid-operation aborts immediately: no `done` pulse, and the outputs are zeroed.
- Latency: `start` is accepted at edge k; `busy` is high after edge k; `done` is high for exactly one cycle after edge k+`lpm_widthn`+1.
  - This counts enabled edges only. `clken`=0 stretches the timeline, and a `done` that is already high stays high while `clken`=0.
- The outputs change only at the FIX edge and are stable between `done` pulses.
- Throughput: one divide per `lpm_widthn`+2 enabled cycles.

## Structure
- Shared package `cnn_div_pkg`:
  - state enum (IDLE, CALC, FIX);
  - representation string constants "UNSIGNED"/"SIGNED";
  - a function returning the magnitude of a two's complement value.
- Sub-module `div_step`: one combinational restoring step. Inputs are the partial remainder, the numerator bit, and the divisor. Outputs are the next remainder and the quotient bit. It is instantiated once and used iteratively.
- The top level holds the FSM, counter, operand shift registers, and sign fix.

## Test plan
- UNSIGNED, n=8, d=4: numer=100, denom=7 → after 9 enabled cycles, `done` pulse, quotient=14, remain=2, `div_by_zero`=0.
- SIGNED, n=8, d=4: numer=−100, denom=7 → quotient=−14 (0xF2), remain=−2 (0xE). Also numer=−128, denom=−1 → quotient=0x80, remain=0.
- denom=0 with numer=255 (UNSIGNED, n=8) → quotient=0xFF, remain=0, `div_by_zero`=1, same 9-cycle latency.
- `start` pulsed again at cycles 3 and 9 of a divide → ignored, and the first result is unchanged. A `start` one cycle after `done` is accepted.
- `clken` low for 5 cycles mid-CALC → `done` arrives 5 cycles late with the correct result. `clken` low during the `done` cycle holds `done` high.
- `aclr` asserted mid-CALC → all outputs 0 asynchronously, no `done`. A new divide after release completes correctly.
